finv_seq: RTL and testbench

Multi-cycle, parametrised FP32 reciprocal unit: the successor to the combinational Newton-Raphson inverter in the FPU.
- Seeds from an elaborated table, runs NR_ITERS Newton iterations on one shared multiplier, then rounds.
- Uses a valid/ready handshake on both sides, so the core FPU can issue into it and stall on it.
- Adds IEEE special-case handling, flush-to-zero and status flags that the combinational version lacks.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/finv_seed_rom.sv | 24 ++
 rtl/finv_seq.sv | 188 ++++++++++++++++++
 tb/tb_finv_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the sequential reciprocal unit: field layout,
// canonical special values, FSM states and the seed-table generator.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StMulA,
    StMulB,
    StRound,
    StDone
  } finv_state_t;

  // Seed for bucket idx: 1/(1+(idx+0.5)*2^-lut_bits) in Q1.frac_w, truncated.
  function automatic logic [63:0] finv_seed(input int unsigned idx,
                                            input int unsigned lut_bits,
                                            input int unsigned frac_w);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (frac_w + lut_bits + 1);
    den = (64'd1 << (lut_bits + 1)) + 64'(2 * idx + 1);
    return num / den;
  endfunction

endpackage

// File: rtl/finv_seed_rom.sv
// Combinational seed table for the Newton-Raphson reciprocal, built at
// elaboration from the package generator function.
module finv_seed_rom
  import fpu_pkg::*;
#(
  parameter int unsigned LUT_BITS = 8,
  parameter int unsigned FRAC_W   = 32
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [FRAC_W+1:0]   seed
);

  localparam int unsigned NUM_ENTRIES = 1 << LUT_BITS;

  logic [FRAC_W+1:0] rom [NUM_ENTRIES];

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_rom
    localparam logic [63:0] SeedVal = finv_seed(i, LUT_BITS, FRAC_W);
    assign rom[i] = SeedVal[FRAC_W+1:0];
  end

  assign seed = rom[idx];

endmodule

// File: rtl/finv_seq.sv
// Multi-cycle FP32 reciprocal: table seed, NR_ITERS Newton steps on one shared
// 24 x (FRAC_W+2) multiplier, round-to-nearest-even, IEEE specials with FTZ.
module finv_seq
  import fpu_pkg::*;
#(
  parameter int unsigned NR_ITERS = 2,
  parameter int unsigned LUT_BITS = 8,
  parameter int unsigned FRAC_W   = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_dz,
  output logic        out_uf,
  output logic        out_nv
);

  localparam int unsigned XW = FRAC_W + 2;
  localparam int unsigned PW = 24 + XW;
  // |1-t| < 2^-(LUT_BITS+1), so scaling it by 2^ES keeps it inside 24 bits.
  localparam int unsigned ES  = LUT_BITS + 23;
  localparam int unsigned SHR = (FRAC_W > ES) ? FRAC_W - ES : 0;
  localparam int unsigned SHL = (ES > FRAC_W) ? ES - FRAC_W : 0;
  localparam int unsigned EW  = XW + SHL;
  localparam logic [XW-1:0] ONE = XW'(1) << FRAC_W;
  localparam logic [2:0] K_LAST = 3'(NR_ITERS - 1);

  finv_state_t      state;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] man_q;
  logic [XW-1:0]    x_q;
  logic [XW-1:0]    t_q;
  logic [2:0]       k_q;

  logic [XW-1:0]    seed;
  logic [23:0]      mul_a;
  logic [PW-1:0]    prod;
  logic             e_neg;
  logic [XW-1:0]    e_abs;
  logic [XW-1:0]    corr;
  logic [XW-1:0]    x_next;
  logic             uf_case;
  logic             special;
  logic [31:0]      sp_data;
  logic             sp_dz, sp_uf, sp_nv;
  logic [7:0]       re;
  logic [MAN_W-1:0] r_man;
  logic             rup;
  logic [23:0]      r_sum;
  logic [31:0]      res;

  finv_seed_rom #(
    .LUT_BITS(LUT_BITS),
    .FRAC_W  (FRAC_W)
  ) u_seed_rom (
    .idx (man_q[MAN_W-1 -: LUT_BITS]),
    .seed(seed)
  );

  // Shared multiplier: M*x in MUL_A, x*|1-t| in MUL_B, plus the Newton update.
  always_comb begin
    e_neg = t_q > ONE;
    e_abs = e_neg ? t_q - ONE : ONE - t_q;
    mul_a = (state == StMulB) ? 24'((EW'(e_abs) << SHL) >> SHR) : {1'b1, man_q};
    prod  = PW'(mul_a) * PW'(x_q);
    corr  = XW'(prod >> ES);
    // x*(2-t) = x + x*(1-t)
    x_next = e_neg ? x_q - corr : x_q + corr;
  end

  // Special-operand decode and exponent / underflow rule.
  always_comb begin
    uf_case = (man_q == '0) ? (exp_q >= 8'd254) : (exp_q >= 8'd253);
    re      = (man_q == '0) ? 8'd254 - exp_q : 8'd253 - exp_q;
    special = 1'b1;
    sp_data = '0;
    sp_dz   = 1'b0;
    sp_uf   = 1'b0;
    sp_nv   = 1'b0;
    if (exp_q == EXP_MAX) begin
      if (man_q != '0) begin
        sp_data = FP_QNAN;
        sp_nv   = 1'b1;
      end else begin
        sp_data = sign_q ? FP_NEG_ZERO : FP_POS_ZERO;
      end
    end else if (exp_q == '0) begin
      sp_data = sign_q ? FP_NEG_INF : FP_POS_INF;
      sp_dz   = 1'b1;
    end else if (uf_case) begin
      sp_data = sign_q ? FP_NEG_ZERO : FP_POS_ZERO;
      sp_uf   = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // Round the Newton estimate (leading one at 2^-1) to nearest even.
  always_comb begin
    r_man = x_q[FRAC_W-2 -: MAN_W];
    rup   = x_q[FRAC_W-25] & ((|x_q[FRAC_W-26:0]) | r_man[0]);
    r_sum = {1'b0, r_man} + 24'(rup);
    if (man_q == '0) begin
      res = {sign_q, re, 23'b0};
    end else if (r_sum[23]) begin
      res = {sign_q, re + 8'd1, 23'b0};
    end else begin
      res = {sign_q, re, r_sum[22:0]};
    end
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dz    <= 1'b0;
      out_uf    <= 1'b0;
      out_nv    <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      man_q     <= '0;
      x_q       <= '0;
      t_q       <= '0;
      k_q       <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            sign_q   <= in_data[31];
            exp_q    <= in_data[MAN_W +: EXP_W];
            man_q    <= in_data[MAN_W-1:0];
            in_ready <= 1'b0;
            state    <= StSeed;
          end
        end
        StSeed: begin
          if (special) begin
            out_data  <= sp_data;
            out_dz    <= sp_dz;
            out_uf    <= sp_uf;
            out_nv    <= sp_nv;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            x_q   <= seed;
            k_q   <= '0;
            state <= StMulA;
          end
        end
        StMulA: begin
          t_q   <= XW'(prod >> 23);
          state <= StMulB;
        end
        StMulB: begin
          x_q   <= x_next;
          k_q   <= k_q + 3'd1;
          state <= (k_q == K_LAST) ? StRound : StMulA;
        end
        StRound: begin
          out_data  <= res;
          out_dz    <= 1'b0;
          out_uf    <= 1'b0;
          out_nv    <= 1'b0;
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_finv_seq.sv
// Bench for finv_seq: two instances (NR=2/LUT=8 and NR=3/LUT=6) driven by
// directed steps and random normals, checked against a double-precision model.
module tb_finv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [1:0]        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]        out_dz, out_uf, out_nv;
  logic [1:0][31:0]  in_data, out_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;  // {dz, uf, nv}
    int          lat;
    int          tol;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  finv_seq #(.NR_ITERS(2), .LUT_BITS(8), .FRAC_W(32)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_dz(out_dz[0]), .out_uf(out_uf[0]), .out_nv(out_nv[0])
  );

  finv_seq #(.NR_ITERS(3), .LUT_BITS(6), .FRAC_W(32)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_dz(out_dz[1]), .out_uf(out_uf[1]), .out_nv(out_nv[1])
  );

  function automatic exp_t mk(input logic [31:0] d, input logic [2:0] f, input int lat,
                              input int tol);
    exp_t e;
    e.data = d; e.flags = f; e.lat = lat; e.tol = tol;
    return e;
  endfunction

  // Reference: widen to double, divide, round the double back to FP32 (RNE).
  function automatic logic [31:0] ref_recip(input logic [31:0] a);
    logic [63:0] db, rb;
    logic [10:0] ex;
    logic [51:0] mn;
    logic [23:0] sum;
    logic [7:0]  e8;
    real         r;
    db  = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
    r   = 1.0 / $bitstoreal(db);
    rb  = $realtobits(r);
    ex  = rb[62:52];
    mn  = rb[51:0];
    sum = {1'b0, mn[51:29]} + 24'(mn[28] & ((|mn[27:0]) | mn[29]));
    e8  = 8'(ex - 11'd896);
    if (sum[23]) begin
      e8  = e8 + 8'd1;
      sum = '0;
    end
    return {rb[63], e8, sum[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] got, input logic [31:0] want);
    logic [31:0] diff;
    diff = (got > want) ? got - want : want - got;
    checks++;
    assert (diff <= 32'd1) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (+-1 ulp)", tag, got, want);
    end
  endtask

  // Issue one operand to unit u and score its result; starts and ends on a negedge.
  task automatic run_op(input int u, input string tag, input logic [31:0] d, input exp_t e);
    int   acc, waited;
    exp_t x;
    sb.push_back(e);
    waited = 0;
    while (in_ready[u] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    in_valid[u] = 1'b0;
    check({tag, "_busy"}, 32'(in_ready[u]), 32'd0);
    waited = 0;
    while (out_valid[u] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    x = sb.pop_front();
    check({tag, "_valid"}, 32'(out_valid[u]), 32'd1);
    if (x.tol == 0) check({tag, "_data"}, out_data[u], x.data);
    else check_ulp({tag, "_data"}, out_data[u], x.data);
    check({tag, "_flags"}, 32'({out_dz[u], out_uf[u], out_nv[u]}), 32'(x.flags));
    check({tag, "_lat"}, 32'(cyc - acc), 32'(x.lat));
    if (out_ready[u] === 1'b1) begin
      @(negedge clk);
      check({tag, "_retire_valid"}, 32'(out_valid[u]), 32'd0);
      check({tag, "_retire_ready"}, 32'(in_ready[u]), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rstn      = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_data", out_data[0], 32'h0);
    check("rst_flags", 32'({out_dz[0], out_uf[0], out_nv[0]}), 32'd0);
    check("rst_in_ready1", 32'(in_ready[1]), 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    // Main function and exact cases
    run_op(0, "two",    32'h4000_0000, mk(32'h3F00_0000, 3'b000, 6, 0));
    run_op(0, "three",  32'h4040_0000, mk(32'h3EAA_AAAB, 3'b000, 6, 0));
    run_op(0, "mfive",  32'hC0A0_0000, mk(32'hBE4C_CCCD, 3'b000, 6, 0));
    // Specials, 1-cycle latency
    run_op(0, "zero",   32'h0000_0000, mk(32'h7F80_0000, 3'b100, 1, 0));
    run_op(0, "mdenorm", 32'h8000_0001, mk(32'hFF80_0000, 3'b100, 1, 0));
    run_op(0, "minf",   32'hFF80_0000, mk(32'h8000_0000, 3'b000, 1, 0));
    run_op(0, "nan",    32'h7FC0_0001, mk(32'h7FC0_0000, 3'b001, 1, 0));
    // Exponent boundaries
    run_op(0, "uf_pow2", 32'h7F00_0000, mk(32'h0000_0000, 3'b010, 1, 0));
    run_op(0, "uf_m",    32'h7E80_0001, mk(32'h0000_0000, 3'b010, 1, 0));
    run_op(0, "min_norm", 32'h7E80_0000, mk(32'h0080_0000, 3'b000, 6, 0));

    // Backpressure: result held, in_valid ignored, single retire
    out_ready[0] = 1'b0;
    run_op(0, "bp", 32'h4040_0000, mk(32'h3EAA_AAAB, 3'b000, 6, 0));
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h4000_0000;
      @(negedge clk);
      check("bp_hold_data", out_data[0], 32'h3EAA_AAAB);
      check("bp_hold_flags", 32'({out_dz[0], out_uf[0], out_nv[0]}), 32'd0);
      check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid[0]), 32'd0);
    check("bp_release_ready", 32'(in_ready[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_no_phantom", 32'(out_valid[0]), 32'd0);
    end

    // Reset during MUL_B abandons the operand
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid[0]), 32'd0);
    check("rst_mid_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_op(0, "after_rst", 32'h4000_0000, mk(32'h3F00_0000, 3'b000, 6, 0));

    // Random normals on the default unit
    for (int i = 0; i < 200; i++) begin
      a = {1'($urandom_range(1, 0)), 8'($urandom_range(252, 1)), 23'($urandom)};
      run_op(0, "rand0", a, mk(ref_recip(a), 3'b000, 6, 1));
    end

    // NR_ITERS=3, LUT_BITS=6 unit
    run_op(1, "u1_two",   32'h4000_0000, mk(32'h3F00_0000, 3'b000, 8, 0));
    run_op(1, "u1_three", 32'h4040_0000, mk(32'h3EAA_AAAB, 3'b000, 8, 0));
    run_op(1, "u1_nan",   32'h7FC0_0001, mk(32'h7FC0_0000, 3'b001, 1, 0));
    for (int i = 0; i < 100; i++) begin
      a = {1'($urandom_range(1, 0)), 8'($urandom_range(252, 1)), 23'($urandom)};
      run_op(1, "rand1", a, mk(ref_recip(a), 3'b000, 8, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
